ecc_job_scheduler: RTL and testbench

ECC_JOB_SCHEDULER -- requirements
Module: ecc_job_scheduler

---
 rtl/ecc_job_scheduler.sv | 277 +++++++++++++++++++++++++++
 tb/tb_ecc_job_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_job_scheduler.sv
// ecc_job_scheduler: round-robin arbiter that accepts one ECC job at a time,
// programs the ECC core over a four-write APB sequence (CODEWORD_WIDTH,
// NOISE, DATA_IN, CTRL), waits for operation_done or a timeout and returns
// a single-cycle response tagged with the requester index.
module ecc_job_scheduler #(
    parameter int NUM_REQ         = 4,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int TIMEOUT         = 64,
    localparam int IDW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [2*NUM_REQ-1:0]           req_op,
    input  logic [2*NUM_REQ-1:0]           req_width,
    input  logic [AMBA_WORD*NUM_REQ-1:0]   req_data,
    input  logic [AMBA_WORD*NUM_REQ-1:0]   req_noise,
    output logic [AMBA_ADDR_WIDTH-1:0]     PADDR,
    output logic [AMBA_WORD-1:0]           PWDATA,
    output logic                           PSEL,
    output logic                           PENABLE,
    output logic                           PWRITE,
    input  logic                           operation_done,
    input  logic [DATA_WIDTH-1:0]          data_out,
    input  logic [1:0]                     num_of_errors,
    output logic                           rsp_valid,
    output logic [IDW-1:0]                 rsp_id,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic [1:0]                     rsp_errors,
    output logic [1:0]                     rsp_status
);

    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_GRANT      = 3'd1;
    localparam logic [2:0] S_APB_SETUP  = 3'd2;
    localparam logic [2:0] S_APB_ACCESS = 3'd3;
    localparam logic [2:0] S_WAIT       = 3'd4;
    localparam logic [2:0] S_RESP       = 3'd5;

    localparam logic [3:0] ADDR_CTRL     = 4'h0;
    localparam logic [3:0] ADDR_DATA_IN  = 4'h4;
    localparam logic [3:0] ADDR_CW_WIDTH = 4'h8;
    localparam logic [3:0] ADDR_NOISE    = 4'hC;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_ILLEGAL = 2'b10;

    logic [2:0]            state_q,    state_d;
    logic [1:0]            reg_idx_q,  reg_idx_d;
    logic [WCW-1:0]        wait_cnt_q, wait_cnt_d;
    logic [IDW-1:0]        rr_ptr_q,   rr_ptr_d;
    logic [IDW-1:0]        id_q,       id_d;
    logic [1:0]            op_q,       op_d;
    logic [1:0]            width_q,    width_d;
    logic [AMBA_WORD-1:0]  data_q,     data_d;
    logic [AMBA_WORD-1:0]  noise_q,    noise_d;
    logic [DATA_WIDTH-1:0] rdata_q,    rdata_d;
    logic [1:0]            rerr_q,     rerr_d;
    logic [1:0]            rstat_q,    rstat_d;

    logic                  grant_found;
    logic [IDW-1:0]        grant_idx;
    logic [1:0]            sel_op;
    logic [1:0]            sel_width;
    logic [AMBA_WORD-1:0]  sel_data;
    logic [AMBA_WORD-1:0]  sel_noise;

    // Candidate index k positions after the round-robin pointer, wrapping.
    function automatic logic [IDW-1:0] rr_cand(input logic [IDW-1:0] ptr, input int k);
        return IDW'((int'(ptr) + k) % NUM_REQ);
    endfunction

    // Round-robin pick: the first valid requester strictly after rr_ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!grant_found && req_valid[rr_cand(rr_ptr_q, k)]) begin
                grant_found = 1'b1;
                grant_idx   = rr_cand(rr_ptr_q, k);
            end
        end
    end

    // Route the granted requester's job fields to the latch inputs.
    always_comb begin
        sel_op    = '0;
        sel_width = '0;
        sel_data  = '0;
        sel_noise = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_op    = req_op[2*i +: 2];
                sel_width = req_width[2*i +: 2];
                sel_data  = req_data[AMBA_WORD*i +: AMBA_WORD];
                sel_noise = req_noise[AMBA_WORD*i +: AMBA_WORD];
            end
        end
    end

    // Next-state logic for the job FSM and its datapath registers.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        reg_idx_d  = reg_idx_q;
        wait_cnt_d = wait_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        id_d       = id_q;
        op_d       = op_q;
        width_d    = width_q;
        data_d     = data_q;
        noise_d    = noise_q;
        rdata_d    = rdata_q;
        rerr_d     = rerr_q;
        rstat_d    = rstat_q;

        case (state_q)
            S_IDLE: begin
                if (|req_valid) state_d = S_GRANT;
            end

            S_GRANT: begin
                if (grant_found) begin
                    rr_ptr_d  = grant_idx;
                    id_d      = grant_idx;
                    op_d      = sel_op;
                    width_d   = sel_width;
                    data_d    = sel_data;
                    noise_d   = sel_noise;
                    reg_idx_d = 2'd0;
                    if (sel_op == 2'b11 || sel_width == 2'b11) begin
                        // Illegal jobs are answered without touching the core.
                        rdata_d = '0;
                        rerr_d  = '0;
                        rstat_d = ST_ILLEGAL;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_APB_SETUP;
                    end
                end else begin
                    // The request vanished between IDLE and GRANT.
                    state_d = S_IDLE;
                end
            end

            S_APB_SETUP: begin
                state_d = S_APB_ACCESS;
            end

            S_APB_ACCESS: begin
                if (reg_idx_q == 2'd3) begin
                    wait_cnt_d = '0;
                    state_d    = S_WAIT;
                end else begin
                    reg_idx_d = reg_idx_q + 2'd1;
                    state_d   = S_APB_SETUP;
                end
            end

            S_WAIT: begin
                // Completion is checked first so it wins a tie with the timeout.
                if (operation_done) begin
                    rdata_d = data_out;
                    rerr_d  = num_of_errors;
                    rstat_d = ST_OK;
                    state_d = S_RESP;
                end else if (wait_cnt_q == WCW'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    rerr_d  = '0;
                    rstat_d = ST_TIMEOUT;
                    state_d = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            S_RESP: begin
                state_d = (|req_valid) ? S_GRANT : S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: payload registers are reset as well; there are few of them and it keeps captured results deterministic after an aborted job.
            state_q    <= S_IDLE;
            reg_idx_q  <= '0;
            wait_cnt_q <= '0;
            rr_ptr_q   <= IDW'(NUM_REQ - 1);
            id_q       <= '0;
            op_q       <= '0;
            width_q    <= '0;
            data_q     <= '0;
            noise_q    <= '0;
            rdata_q    <= '0;
            rerr_q     <= '0;
            rstat_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values together.
            state_q    <= state_d;
            reg_idx_q  <= reg_idx_d;
            wait_cnt_q <= wait_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            id_q       <= id_d;
            op_q       <= op_d;
            width_q    <= width_d;
            data_q     <= data_d;
            noise_q    <= noise_d;
            rdata_q    <= rdata_d;
            rerr_q     <= rerr_d;
            rstat_q    <= rstat_d;
        end
    end

    // Outputs decode from registered state, so reset forces them to zero at once.
    always_comb begin
        req_ready  = '0;
        PSEL       = 1'b0;
        PENABLE    = 1'b0;
        PWRITE     = 1'b0;
        PADDR      = '0;
        PWDATA     = '0;
        rsp_valid  = 1'b0;
        rsp_id     = '0;
        rsp_data   = '0;
        rsp_errors = '0;
        rsp_status = '0;

        for (int i = 0; i < NUM_REQ; i++) begin
            if (state_q == S_GRANT && grant_found && grant_idx == IDW'(i)) req_ready[i] = 1'b1;
        end

        if (state_q == S_APB_SETUP || state_q == S_APB_ACCESS) begin
            PSEL    = 1'b1;
            PWRITE  = 1'b1;
            PENABLE = (state_q == S_APB_ACCESS);
            case (reg_idx_q)
                2'd0: begin
                    PADDR  = AMBA_ADDR_WIDTH'(ADDR_CW_WIDTH);
                    PWDATA = AMBA_WORD'(width_q);
                end
                2'd1: begin
                    PADDR  = AMBA_ADDR_WIDTH'(ADDR_NOISE);
                    PWDATA = noise_q;
                end
                2'd2: begin
                    PADDR  = AMBA_ADDR_WIDTH'(ADDR_DATA_IN);
                    PWDATA = data_q;
                end
                default: begin
                    PADDR  = AMBA_ADDR_WIDTH'(ADDR_CTRL);
                    PWDATA = AMBA_WORD'(op_q);
                end
            endcase
        end

        if (state_q == S_RESP) begin
            rsp_valid  = 1'b1;
            rsp_id     = id_q;
            rsp_data   = rdata_q;
            rsp_errors = rerr_q;
            rsp_status = rstat_q;
        end
    end

endmodule

// File: tb/tb_ecc_job_scheduler.sv
// Testbench for ecc_job_scheduler: directed jobs, a scoreboard of expected
// APB writes and responses, a monitor that pops and compares them, and a
// small ECC core model answering the CTRL write.
module tb_ecc_job_scheduler;

    localparam int NUM_REQ = 4;
    localparam int AW      = 20;
    localparam int AWD     = 32;
    localparam int DW      = 32;
    localparam int TMO     = 16;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic [2*NUM_REQ-1:0]     req_op = '0;
    logic [2*NUM_REQ-1:0]     req_width = '0;
    logic [AWD*NUM_REQ-1:0]   req_data = '0;
    logic [AWD*NUM_REQ-1:0]   req_noise = '0;
    logic [AW-1:0]            PADDR;
    logic [AWD-1:0]           PWDATA;
    logic                     PSEL, PENABLE, PWRITE;
    logic                     operation_done = 1'b0;
    logic [DW-1:0]            data_out = '0;
    logic [1:0]               num_of_errors = '0;
    logic                     rsp_valid;
    logic [1:0]               rsp_id;
    logic [DW-1:0]            rsp_data;
    logic [1:0]               rsp_errors;
    logic [1:0]               rsp_status;

    ecc_job_scheduler #(
        .NUM_REQ(NUM_REQ), .AMBA_ADDR_WIDTH(AW), .AMBA_WORD(AWD),
        .DATA_WIDTH(DW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_width(req_width),
        .req_data(req_data), .req_noise(req_noise),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .operation_done(operation_done), .data_out(data_out), .num_of_errors(num_of_errors),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_errors(rsp_errors), .rsp_status(rsp_status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]  addr;
        logic [AWD-1:0] data;
    } apb_t;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        logic [1:0]    err;
        logic [1:0]    status;
    } rsp_t;

    apb_t exp_apb[$];
    rsp_t exp_rsp[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ctrl_cyc = 0, setup0_cyc = 0, rsp_cyc = 0;

    // Core model knobs: delay after the CTRL write (-1 = never answer).
    int          core_delay  = 1;
    logic [31:0] core_xor    = '0;
    logic [1:0]  core_nerr   = '0;
    bit          spurious_en = 1'b0;
    logic [31:0] last_din    = '0;

    bit              setup_seen = 1'b0;
    logic [AW-1:0]   s_addr;
    logic [AWD-1:0]  s_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic [1:0] op, input logic [1:0] w,
                           input logic [31:0] d, input logic [31:0] n);
        req_op[2*idx +: 2]      = op;
        req_width[2*idx +: 2]   = w;
        req_data[AWD*idx +: AWD]  = d;
        req_noise[AWD*idx +: AWD] = n;
    endtask

    task automatic push_apb(input logic [1:0] op, input logic [1:0] w,
                            input logic [31:0] d, input logic [31:0] n);
        exp_apb.push_back('{addr: 20'h8, data: {30'b0, w}});
        exp_apb.push_back('{addr: 20'hC, data: n});
        exp_apb.push_back('{addr: 20'h4, data: d});
        exp_apb.push_back('{addr: 20'h0, data: {30'b0, op}});
    endtask

    task automatic push_rsp(input int id, input logic [31:0] d, input logic [1:0] e, input logic [1:0] s);
        exp_rsp.push_back('{id: id, data: d, err: e, status: s});
    endtask

    // Wait (bounded) for a handshake and return the granted index.
    task automatic wait_grant(output int gidx);
        bit seen;
        seen = 1'b0;
        gidx = -1;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            if ((req_ready & req_valid) != '0) begin
                seen = 1'b1;
                check("grant_onehot", $countones(req_ready), 1);
                for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) gidx = i;
            end
        end
        check("grant_seen", seen, 1);
    endtask

    // Wait (bounded) until every expected response has been consumed.
    task automatic drain();
        for (int t = 0; t < 300 && exp_rsp.size() != 0; t++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("rsp_drained", exp_rsp.size(), 0);
        check("apb_drained", exp_apb.size(), 0);
    endtask

    task automatic single_job(input int idx, input logic [1:0] op, input logic [1:0] w,
                              input logic [31:0] d, input logic [31:0] n,
                              input logic [31:0] rdata, input logic [1:0] rerr, input logic [1:0] rstat);
        int g;
        bit legal;
        legal = (op != 2'b11) && (w != 2'b11);
        set_req(idx, op, w, d, n);
        if (legal) push_apb(op, w, d, n);
        push_rsp(idx, rdata, rerr, rstat);
        req_valid[idx] = 1'b1;
        wait_grant(g);
        check("grant_id", g, idx);
        @(posedge clk);
        #1;
        // Drop and scramble the request: the job in flight must not notice.
        req_valid[idx] = 1'b0;
        set_req(idx, 2'b11, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        if (legal) check("setup_after_accept", {PSEL, PENABLE, PADDR}, {1'b1, 1'b0, 20'h8});
        else       check("illegal_rsp_after_accept", {rsp_valid, PSEL}, 2'b10);
        drain();
    endtask

    task automatic multi_grant(input logic [NUM_REQ-1:0] mask, input int order[4], input int n);
        int g;
        req_valid = mask;
        for (int k = 0; k < n; k++) begin
            wait_grant(g);
            check("rr_order", g, order[k]);
            @(posedge clk);
            #1;
            if (k == n - 1) req_valid = '0;
        end
        drain();
    endtask

    // Scoreboard monitor: APB protocol/writes and responses, sampled on negedge.
    initial begin
        forever begin
            @(negedge clk);
            if (PSEL && !PENABLE) begin
                check("apb_setup_pwrite", PWRITE, 1);
                setup_seen = 1'b1;
                s_addr = PADDR;
                s_data = PWDATA;
                if (PADDR == 20'h8) setup0_cyc = cyc;
            end else if (PSEL && PENABLE) begin
                check("apb_access_after_setup", setup_seen, 1);
                check("apb_stable", {PADDR, PWDATA}, {s_addr, s_data});
                check("apb_access_pwrite", PWRITE, 1);
                if (exp_apb.size() == 0) begin
                    check("apb_unexpected", PSEL, 0);
                end else begin
                    apb_t e;
                    e = exp_apb.pop_front();
                    check("apb_addr", PADDR, e.addr);
                    check("apb_data", PWDATA, e.data);
                end
                if (PADDR == 20'h0) ctrl_cyc = cyc;
                setup_seen = 1'b0;
            end else begin
                setup_seen = 1'b0;
                check("apb_idle", {PENABLE, PWRITE, |PADDR, |PWDATA}, 0);
            end

            if (rsp_valid) begin
                rsp_cyc = cyc;
                if (exp_rsp.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 0);
                end else begin
                    rsp_t r;
                    r = exp_rsp.pop_front();
                    check("rsp_id", rsp_id, r.id);
                    check("rsp_data", rsp_data, r.data);
                    check("rsp_errors", rsp_errors, r.err);
                    check("rsp_status", rsp_status, r.status);
                end
            end
        end
    end

    // ECC core model: answers a CTRL write after core_delay cycles.
    initial begin
        forever begin
            @(negedge clk);
            operation_done = 1'b0;
            if (PSEL && PENABLE) begin
                if (PADDR == 20'h4) last_din = PWDATA;
                if (PADDR == 20'hC && spurious_en) begin
                    operation_done = 1'b1;
                    data_out       = 32'hDEAD_BEEF;
                    num_of_errors  = 2'b11;
                end
                if (PADDR == 20'h0 && core_delay > 0) begin
                    repeat (core_delay) @(negedge clk);
                    operation_done = 1'b1;
                    data_out       = last_din ^ core_xor;
                    num_of_errors  = core_nerr;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        bit found;

        // Reset state, during and after reset.
        #1;
        check("reset_outputs", {req_ready, PSEL, PENABLE, PWRITE, |PADDR, |PWDATA, rsp_valid}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_outputs", {req_ready, PSEL, rsp_valid, rsp_status}, 0);

        // Single encode: 0x5 ^ 0xAE = 0xAB from the core.
        core_delay = 1; core_xor = 32'hAE; core_nerr = 2'b00;
        single_job(0, 2'b00, 2'b00, 32'h5, 32'h10, 32'hAB, 2'b00, 2'b00);
        check("apb_seq_len", ctrl_cyc - setup0_cyc, 7);
        check("done_to_rsp", rsp_cyc - ctrl_cyc, 2);

        // Round robin with requesters 1..3 held valid: order 1,2,3,1.
        core_delay = 3; core_xor = '0; core_nerr = 2'b10;
        set_req(1, 2'b01, 2'b01, 32'h11, 32'h100);
        set_req(2, 2'b00, 2'b10, 32'h22, 32'h200);
        set_req(3, 2'b10, 2'b00, 32'h33, 32'h300);
        push_apb(2'b01, 2'b01, 32'h11, 32'h100); push_rsp(1, 32'h11, 2'b10, 2'b00);
        push_apb(2'b00, 2'b10, 32'h22, 32'h200); push_rsp(2, 32'h22, 2'b10, 2'b00);
        push_apb(2'b10, 2'b00, 32'h33, 32'h300); push_rsp(3, 32'h33, 2'b10, 2'b00);
        push_apb(2'b01, 2'b01, 32'h11, 32'h100); push_rsp(1, 32'h11, 2'b10, 2'b00);
        multi_grant(4'b1110, '{1, 2, 3, 1}, 4);

        // Timeout: the core never answers; data_out still holds a stale value.
        core_delay = -1;
        single_job(3, 2'b00, 2'b01, 32'h77, 32'h0, 32'h0, 2'b00, 2'b01);
        check("timeout_latency", rsp_cyc - ctrl_cyc, TMO + 1);

        // Illegal op and illegal width: no APB traffic, status 10.
        single_job(2, 2'b11, 2'b00, 32'h99, 32'h1, 32'h0, 2'b00, 2'b10);
        single_job(1, 2'b00, 2'b11, 32'h98, 32'h1, 32'h0, 2'b00, 2'b10);

        // Full channel with a spurious done during the NOISE write.
        core_delay = 2; core_xor = '0; core_nerr = 2'b01; spurious_en = 1'b1;
        single_job(0, 2'b10, 2'b10, 32'hCAFE_0001, 32'h1, 32'hCAFE_0001, 2'b01, 2'b00);
        spurious_en = 1'b0;

        // Done arrives on the last wait cycle: done wins over timeout.
        core_delay = TMO; core_xor = 32'h0F0F_0000; core_nerr = 2'b10;
        single_job(1, 2'b01, 2'b10, 32'h1234_5678, 32'h4, 32'h1D3B_5678, 2'b10, 2'b00);
        check("tie_latency", rsp_cyc - ctrl_cyc, TMO + 1);

        // Reset asserted during the CTRL setup phase of a job from requester 1.
        core_delay = -1;
        set_req(1, 2'b00, 2'b01, 32'h1234, 32'h8);
        push_apb(2'b00, 2'b01, 32'h1234, 32'h8);
        req_valid[1] = 1'b1;
        wait_grant(g);
        check("pre_reset_grant", g, 1);
        @(posedge clk);
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            @(negedge clk);
            if (PSEL && !PENABLE && PADDR == 20'h0) found = 1'b1;
        end
        check("ctrl_setup_seen", found, 1);
        rst = 1'b0;
        req_valid = '0;
        #1;
        check("reset_apb_off", {PSEL, PENABLE, PWRITE, |PADDR, |PWDATA}, 0);
        check("reset_rsp_off", {rsp_valid, req_ready}, 0);
        exp_apb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);

        // After reset requester 0 wins over requester 2.
        core_delay = 1; core_xor = '0; core_nerr = 2'b00;
        set_req(0, 2'b00, 2'b00, 32'hA0, 32'h0);
        set_req(2, 2'b01, 2'b01, 32'hA2, 32'h2);
        push_apb(2'b00, 2'b00, 32'hA0, 32'h0); push_rsp(0, 32'hA0, 2'b00, 2'b00);
        push_apb(2'b01, 2'b01, 32'hA2, 32'h2); push_rsp(2, 32'hA2, 2'b00, 2'b00);
        multi_grant(4'b0101, '{0, 2, 0, 0}, 2);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
